// File: rtl/ddr_arb_pkg.sv
// Shared types and width defaults for the DDR port arbiter, the cache manage
// unit and ddr_ctrl.
package ddr_arb_pkg;

    localparam int DDR_ADDR_W  = 30;
    localparam int DDR_BLOCK_W = 256;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP,
        GAP
    } arb_state_t;

endpackage

// File: rtl/ddr_watchdog.sv
// Saturating transaction watchdog: clear restarts the count, enable advances it,
// and the sticky expired flag rises when the count first reaches all-ones.
module ddr_watchdog #(
    parameter int TMO_W = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [TMO_W-1:0] CNT_MAX = '1;

    logic [TMO_W-1:0] count;
    logic [TMO_W-1:0] count_inc;

    assign count_inc = count + 1'b1;

    // expired is only ever set here; leaving it alone on clear keeps it sticky
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count   <= '0;
            expired <= 1'b0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != CNT_MAX)) begin
            count <= count_inc;
            if (count_inc == CNT_MAX) begin
                expired <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/ddr_port_arbiter.sv
// Round-robin arbiter sharing the block-wide ddr_ctrl port between the cache
// manage unit (port 0) and the boot-loader copy engine (port 1).
module ddr_port_arbiter
    import ddr_arb_pkg::*;
#(
    parameter int ADDR_W  = DDR_ADDR_W,
    parameter int BLOCK_W = DDR_BLOCK_W,
    parameter int TMO_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req0_en,
    input  logic               req0_write,
    input  logic [ADDR_W-1:0]  req0_addr,
    input  logic [BLOCK_W-1:0] req0_wdata,
    input  logic               req1_en,
    input  logic               req1_write,
    input  logic [ADDR_W-1:0]  req1_addr,
    input  logic [BLOCK_W-1:0] req1_wdata,
    output logic               rdy0,
    output logic               rdy1,
    output logic [BLOCK_W-1:0] rdata,
    output logic               ram_en,
    output logic               ram_write,
    output logic [ADDR_W-1:0]  ram_addr,
    output logic [BLOCK_W-1:0] ram_wdata,
    input  logic               ram_rdy,
    input  logic [BLOCK_W-1:0] ram_block,
    output logic               owner,
    output logic               busy,
    output logic               timeout_err
);

    arb_state_t state;
    arb_state_t state_next;

    logic               last;
    logic               grant;
    logic               grant_port;
    logic               sel_write;
    logic [ADDR_W-1:0]  sel_addr;
    logic [BLOCK_W-1:0] sel_wdata;
    logic               done;

    // On a tie the port that was not served last wins
    always_comb begin
        state_next = state;
        grant      = 1'b0;
        grant_port = last;
        case (state)
            IDLE: begin
                if (req0_en && req1_en) begin
                    grant      = 1'b1;
                    grant_port = ~last;
                end else if (req0_en) begin
                    grant      = 1'b1;
                    grant_port = 1'b0;
                end else if (req1_en) begin
                    grant      = 1'b1;
                    grant_port = 1'b1;
                end
                if (grant) begin
                    state_next = WAIT;
                end
            end
            WAIT:    if (ram_rdy) state_next = RESP;
            RESP:    state_next = GAP;
            GAP:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign sel_write = grant_port ? req1_write : req0_write;
    assign sel_addr  = grant_port ? req1_addr  : req0_addr;
    assign sel_wdata = grant_port ? req1_wdata : req0_wdata;
    assign done      = (state == WAIT) && ram_rdy;

    // The ram_* registers double as the latched request, so later requester
    // changes cannot reach ddr_ctrl until the next grant.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            last      <= 1'b1;
            owner     <= 1'b0;
            busy      <= 1'b0;
            rdy0      <= 1'b0;
            rdy1      <= 1'b0;
            rdata     <= '0;
            ram_en    <= 1'b0;
            ram_write <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
        end else begin
            state <= state_next;
            busy  <= (state_next != IDLE);
            rdy0  <= 1'b0;
            rdy1  <= 1'b0;
            if (grant) begin
                owner     <= grant_port;
                last      <= grant_port;
                ram_en    <= 1'b1;
                ram_write <= sel_write;
                ram_addr  <= sel_addr;
                ram_wdata <= sel_wdata;
            end
            if (done) begin
                ram_en <= 1'b0;
                rdy0   <= ~owner;
                rdy1   <= owner;
                if (!ram_write) begin
                    rdata <= ram_block;
                end
            end
        end
    end

    ddr_watchdog #(
        .TMO_W(TMO_W)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (grant),
        .enable  (state == WAIT),
        .expired (timeout_err)
    );

endmodule

// File: tb/tb_ddr_port_arbiter.sv
// Scoreboard bench for ddr_port_arbiter: requester and ddr_ctrl models drive the
// DUT while a monitor compares every grant and completion against queued entries.
module tb_ddr_port_arbiter;

    typedef struct {
        bit           port;
        bit           write;
        logic [29:0]  addr;
        logic [29:0]  addr2;
        bit           mutate;
        logic [255:0] wdata;
        logic [255:0] rdata;
    } txn_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         req0_en = 1'b0, req0_write = 1'b0;
    logic [29:0]  req0_addr = '0;
    logic [255:0] req0_wdata = '0;
    logic         req1_en = 1'b0, req1_write = 1'b0;
    logic [29:0]  req1_addr = '0;
    logic [255:0] req1_wdata = '0;
    logic         rdy0, rdy1, ram_en, ram_write, owner, busy, timeout_err;
    logic [255:0] rdata, ram_wdata;
    logic [29:0]  ram_addr;
    logic         ram_rdy = 1'b0;
    logic [255:0] ram_block = '0;

    txn_t         exp_q[$];
    txn_t         cmd_q0[$];
    txn_t         cmd_q1[$];
    int           check_count = 0;
    int           pass_count = 0;
    int           ddr_delay = 5;
    int           gap_log = 0;
    int           low_busy_cnt = 0;
    logic [255:0] rdata_model = '0;

    ddr_port_arbiter #(.TMO_W(4)) dut (
        .clk(clk), .rst(rst),
        .req0_en(req0_en), .req0_write(req0_write), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .req1_en(req1_en), .req1_write(req1_write), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .rdy0(rdy0), .rdy1(rdy1), .rdata(rdata),
        .ram_en(ram_en), .ram_write(ram_write), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdy(ram_rdy), .ram_block(ram_block),
        .owner(owner), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    function automatic logic [255:0] block_for(input logic [29:0] a);
        if (a == 30'h40) return {32{8'hA5}};
        return {8{2'b01, a}};
    endfunction

    function automatic logic [255:0] rand_block();
        logic [255:0] b;
        for (int i = 0; i < 8; i++) b[i*32 +: 32] = $urandom;
        return b;
    endfunction

    task automatic checkOutput(input string tag, input logic [255:0] actual, input logic [255:0] expected);
        check_count++;
        if (actual === expected) pass_count++;
        else $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    endtask

    task automatic applyStimulus(input bit port, input bit write, input logic [29:0] addr,
                                 input bit mutate, input logic [29:0] addr2);
        txn_t t;
        t.port   = port;
        t.write  = write;
        t.addr   = addr;
        t.addr2  = addr2;
        t.mutate = mutate;
        t.wdata  = rand_block();
        t.rdata  = block_for(addr);
        exp_q.push_back(t);
        if (port) cmd_q1.push_back(t);
        else      cmd_q0.push_back(t);
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(posedge clk);
            n++;
        end
        #1;
        checkOutput(tag, exp_q.size(), 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        checkOutput({tag, "_ram_en"}, ram_en, 0);
        checkOutput({tag, "_ram_write"}, ram_write, 0);
        checkOutput({tag, "_ram_addr"}, ram_addr, 0);
        checkOutput({tag, "_ram_wdata"}, ram_wdata, 0);
        checkOutput({tag, "_rdata"}, rdata, 0);
        checkOutput({tag, "_rdy"}, {rdy1, rdy0}, 0);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_owner"}, owner, 0);
        checkOutput({tag, "_timeout"}, timeout_err, 0);
    endtask

    // ddr_ctrl model: ram_rdy after ddr_delay cycles of ram_en, garbage otherwise
    initial begin : ddr_model
        int wait_cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            ram_rdy   = 1'b0;
            ram_block = rand_block();
            if (!ram_en) wait_cnt = 0;
            else begin
                wait_cnt++;
                if (wait_cnt == ddr_delay) begin
                    ram_rdy   = 1'b1;
                    ram_block = block_for(ram_addr);
                end
            end
        end
    end

    // Requesters hold en until their rdy pulse, then drop it for a cycle
    initial begin : requester0
        txn_t c;
        int held;
        bit done;
        forever begin
            @(posedge clk);
            #1;
            if (cmd_q0.size() != 0 && rst) begin
                c = cmd_q0.pop_front();
                req0_en = 1'b1; req0_write = c.write; req0_addr = c.addr; req0_wdata = c.wdata;
                held = 0;
                done = 1'b0;
                while (!done && rst && held < 200) begin
                    @(negedge clk);
                    if (rdy0) done = 1'b1;
                    else begin
                        @(posedge clk);
                        #1;
                        held++;
                        if (c.mutate && held == 3) req0_addr = c.addr2;
                    end
                end
                if (rst) checkOutput("req0_done", done, 1);
                @(posedge clk);
                #1;
                req0_en = 1'b0;
            end
        end
    end

    initial begin : requester1
        txn_t c;
        int held;
        bit done;
        forever begin
            @(posedge clk);
            #1;
            if (cmd_q1.size() != 0 && rst) begin
                c = cmd_q1.pop_front();
                req1_en = 1'b1; req1_write = c.write; req1_addr = c.addr; req1_wdata = c.wdata;
                held = 0;
                done = 1'b0;
                while (!done && rst && held < 200) begin
                    @(negedge clk);
                    if (rdy1) done = 1'b1;
                    else begin
                        @(posedge clk);
                        #1;
                        held++;
                        if (c.mutate && held == 3) req1_addr = c.addr2;
                    end
                end
                if (rst) checkOutput("req1_done", done, 1);
                @(posedge clk);
                #1;
                req1_en = 1'b0;
            end
        end
    end

    // Monitor: grants and completions checked against the scoreboard front
    initial begin : monitor
        txn_t e;
        bit ram_en_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                ram_en_prev  = 1'b0;
                low_busy_cnt = 0;
            end else begin
                if (!ram_en && busy) low_busy_cnt++;
                if (ram_en) begin
                    if (exp_q.size() == 0) checkOutput("unexpected_ram_en", ram_en, 0);
                    else begin
                        if (!ram_en_prev) begin
                            gap_log      = low_busy_cnt;
                            low_busy_cnt = 0;
                            checkOutput("owner", owner, exp_q[0].port);
                            checkOutput("ram_write", ram_write, exp_q[0].write);
                            if (exp_q[0].write) checkOutput("ram_wdata", ram_wdata, exp_q[0].wdata);
                        end
                        checkOutput("ram_addr", ram_addr, exp_q[0].addr);
                    end
                end
                if (rdy0 || rdy1) begin
                    if (exp_q.size() == 0) checkOutput("unexpected_rdy", {rdy1, rdy0}, 0);
                    else begin
                        e = exp_q.pop_front();
                        checkOutput("rdy_port", {rdy1, rdy0}, e.port ? 2'b10 : 2'b01);
                        if (!e.write) rdata_model = e.rdata;
                        checkOutput("rdata", rdata, rdata_model);
                    end
                end
                ram_en_prev = ram_en;
            end
        end
    end

    task automatic pulse_reset();
        rst = 1'b0;
        exp_q.delete();
        cmd_q0.delete();
        cmd_q1.delete();
        rdata_model = '0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin : main
        int n;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Single read, port 0
        ddr_delay = 5;
        applyStimulus(0, 0, 30'h40, 0, 0);
        wait_drain("t1_drain");
        checkOutput("t1_rdata", rdata, {32{8'hA5}});

        // Simultaneous requests straight after reset
        pulse_reset();
        ddr_delay = 2;
        applyStimulus(0, 1, 30'h100, 0, 0);
        applyStimulus(1, 0, 30'h200, 0, 0);
        wait_drain("t2_drain");
        checkOutput("t2_gap", gap_log, 2);

        // Both ports requesting continuously: strict alternation from port 0
        ddr_delay = 3;
        for (int i = 0; i < 6; i++)
            applyStimulus(i[0], (i % 3) == 0, 30'h1000 + 30'(i * 8), 0, 0);
        wait_drain("t3_drain");

        // Requester address change during WAIT has no effect
        ddr_delay = 6;
        applyStimulus(1, 0, 30'h300, 1, 30'h304);
        wait_drain("t4_drain");

        // Watchdog with late ram_rdy
        ddr_delay = 20;
        applyStimulus(0, 0, 30'h500, 0, 0);
        n = 0;
        while (!ram_en && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("t5_grant", ram_en, 1);
        repeat (14) @(posedge clk);
        #1;
        checkOutput("t5_tmo_before", timeout_err, 0);
        @(posedge clk);
        #1;
        checkOutput("t5_tmo_set", timeout_err, 1);
        wait_drain("t5_drain");
        ddr_delay = 2;
        applyStimulus(1, 1, 30'h508, 0, 0);
        wait_drain("t5b_drain");
        checkOutput("t5_tmo_sticky", timeout_err, 1);

        // Reset during WAIT: immediate reset values, no rdy pulse
        ddr_delay = 100;
        applyStimulus(0, 0, 30'h600, 0, 0);
        n = 0;
        while (!ram_en && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("t6_grant", ram_en, 1);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_reset_outputs("t6_async");
        pulse_reset();
        repeat (4) @(posedge clk);
        #1;
        check_reset_outputs("t6_after");

        // Fresh port-1 request after reset
        ddr_delay = 1;
        applyStimulus(1, 0, 30'h700, 0, 0);
        wait_drain("t7_drain");
        checkOutput("t7_rdata", rdata, block_for(30'h700));
        checkOutput("t7_tmo", timeout_err, 0);

        $display("[TB] %0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
